// File: rtl/nes_pkg.sv
// Shared NES definitions used by the OAM DMA sequencer.
package nes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] NES_OAMDMA_ADDR = 16'h4014;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU bus / OAM write port bundle between the system and the sprite DMA sequencer.
interface oam_dma_ctrl_if;

    logic [15:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_din;
    logic [7:0]  oam_addr_base;
    logic        dma_hijack;
    logic [15:0] dma_addr;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        dma_done;

    modport master (
        output bus_addr, bus_wr, bus_din, oam_addr_base,
        input  dma_hijack, dma_addr, oam_we, oam_addr, oam_data, dma_done
    );

    modport slave (
        input  bus_addr, bus_wr, bus_din, oam_addr_base,
        output dma_hijack, dma_addr, oam_we, oam_addr, oam_data, dma_done
    );

endinterface

// File: rtl/oam_dma_ctrl.sv
// $4014 sprite DMA: stalls the CPU and copies one 256-byte page into PPU OAM
// as alternating read/write cycles, with every read landing on an even (par==0) cycle.
module oam_dma_ctrl
    import nes_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = NES_OAMDMA_ADDR,
    parameter int          XFER_LEN     = 256
) (
    input  logic           cpu_clk,
    input  logic           reset,
    oam_dma_ctrl_if.slave  cpu_bus
);

    localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

    dma_state_t  r_state;
    logic        r_par;
    logic [7:0]  r_page;
    logic [7:0]  r_base;
    logic [7:0]  r_idx;
    logic        r_hijack;
    logic [15:0] r_dma_addr;
    logic        r_oam_we;
    logic [7:0]  r_oam_addr;
    logic [7:0]  r_oam_data;
    logic        r_dma_done;
    logic        w_trigger;

    assign w_trigger = (r_state == IDLE) && !cpu_bus.bus_wr &&
                       (cpu_bus.bus_addr == DMA_REG_ADDR);

    // Outputs are registered: each branch sets the values for the state being entered.
    always_ff @(posedge cpu_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_par      <= 1'b0;
            r_page     <= 8'h00;
            r_base     <= 8'h00;
            r_idx      <= 8'h00;
            r_hijack   <= 1'b0;
            r_dma_addr <= 16'h0000;
            r_oam_we   <= 1'b0;
            r_oam_addr <= 8'h00;
            r_oam_data <= 8'h00;
            r_dma_done <= 1'b0;
        end else begin
            r_par      <= ~r_par;
            r_dma_done <= 1'b0;
            r_oam_we   <= 1'b0;
            r_oam_addr <= 8'h00;
            r_oam_data <= 8'h00;
            r_dma_addr <= 16'h0000;
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        r_page   <= cpu_bus.bus_din;
                        r_base   <= cpu_bus.oam_addr_base;
                        r_idx    <= 8'h00;
                        r_hijack <= 1'b1;
                        r_state  <= HALT;
                    end
                end
                HALT: begin
                    // An odd HALT cycle means the next cycle is even and can read directly.
                    if (r_par) begin
                        r_dma_addr <= {r_page, r_idx};
                        r_state    <= READ;
                    end else begin
                        r_state <= ALIGN;
                    end
                end
                ALIGN: begin
                    r_dma_addr <= {r_page, r_idx};
                    r_state    <= READ;
                end
                READ: begin
                    r_oam_we   <= 1'b1;
                    r_oam_addr <= r_base + r_idx;
                    r_oam_data <= cpu_bus.bus_din;
                    r_state    <= WRITE;
                end
                WRITE: begin
                    if (r_idx == LAST_IDX) begin
                        r_hijack   <= 1'b0;
                        r_dma_done <= 1'b1;
                        r_state    <= IDLE;
                    end else begin
                        r_idx      <= r_idx + 8'd1;
                        r_dma_addr <= {r_page, r_idx + 8'd1};
                        r_state    <= READ;
                    end
                end
                default: begin
                    r_hijack <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign cpu_bus.dma_hijack = r_hijack;
    assign cpu_bus.dma_addr   = r_dma_addr;
    assign cpu_bus.oam_we     = r_oam_we;
    assign cpu_bus.oam_addr   = r_oam_addr;
    assign cpu_bus.oam_data   = r_oam_data;
    assign cpu_bus.dma_done   = r_dma_done;

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized bench for oam_dma_ctrl: a memory model answers DMA reads and a
// transfer-level model predicts the OAM writes, read addresses and stall length.
module tb_oam_dma_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    oam_dma_ctrl_if bif();

    logic [7:0] cpuDin;
    logic [7:0] mem [0:65535];

    // While the DMA owns the bus, memory drives the data bus at the DMA address.
    assign bif.bus_din = bif.dma_hijack ? mem[bif.dma_addr] : cpuDin;

    oam_dma_ctrl #(
        .DMA_REG_ADDR(16'h4014),
        .XFER_LEN(256)
    ) dut (
        .cpu_clk(clk),
        .reset(reset),
        .cpu_bus(bif)
    );

    // Reference cycle parity: cleared by reset, flips every clock.
    bit tbPar;
    always @(posedge clk) begin
        if (reset) tbPar <= 1'b0;
        else       tbPar <= ~tbPar;
    end

    int errors = 0;
    int checks = 0;
    int expHijack;
    logic [15:0] expWrites [$];
    logic [15:0] expReads [$];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outVec();
        return {30'd0, bif.dma_hijack, bif.oam_we, bif.dma_done,
                bif.oam_addr, bif.oam_data, bif.dma_addr};
    endfunction

    // Drives a $4014 write at the current negedge and builds the expected transfer.
    task automatic applyStimulus(input logic [7:0] page, input logic [7:0] base);
        bif.bus_addr      = 16'h4014;
        bif.bus_wr        = 1'b0;
        cpuDin            = page;
        bif.oam_addr_base = base;
        expHijack = tbPar ? 514 : 513;
        expWrites.delete();
        expReads.delete();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] idx;
            logic [7:0] oa;
            idx = 8'(i);
            oa  = base + idx;
            expReads.push_back({page, idx});
            expWrites.push_back({oa, mem[{page, idx}]});
        end
        @(negedge clk);
        bif.bus_wr        = 1'b1;
        bif.bus_addr      = 16'($urandom_range(0, 16'h3fff));
        cpuDin            = 8'($urandom);
        bif.oam_addr_base = 8'($urandom);
    endtask

    // Samples from the HALT cycle until dma_done; returns on the dma_done negedge.
    task automatic monitorTransfer(input string name, input int spuriousAt, input int resetAtWe);
        int hij = 0, dones = 0, parErr = 0, wrErr = 0, rdErr = 0, nWr = 0, nRd = 0;
        bit finished = 0, aborted = 0;
        for (int k = 0; k < 700 && !finished; k++) begin
            if (k > 0) @(negedge clk);
            if (k == spuriousAt) begin
                bif.bus_addr = 16'h4014;
                bif.bus_wr   = 1'b0;
            end else if (k == spuriousAt + 1) begin
                bif.bus_wr   = 1'b1;
                bif.bus_addr = 16'h0000;
            end
            if (bif.dma_hijack) hij++;
            if (bif.dma_done) begin
                dones++;
                finished = 1;
            end
            if (bif.oam_we) begin
                if (nWr < 256 && {bif.oam_addr, bif.oam_data} !== expWrites[nWr]) wrErr++;
                if (bif.dma_addr != 16'h0000) rdErr++;
                nWr++;
            end else if (bif.oam_addr != 8'h00 || bif.oam_data != 8'h00) begin
                wrErr++;
            end
            if (bif.dma_addr != 16'h0000) begin
                if (tbPar != 1'b0) parErr++;
                if (nRd < 256 && bif.dma_addr !== expReads[nRd]) rdErr++;
                nRd++;
            end
            if (resetAtWe > 0 && bif.oam_we && nWr == resetAtWe) begin
                reset = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                checkOutput({name, "_rst_hijack"}, bif.dma_hijack, 0);
                checkOutput({name, "_rst_we"}, bif.oam_we, 0);
                checkOutput({name, "_rst_done"}, bif.dma_done, 0);
                finished = 1;
                aborted  = 1;
            end
        end
        if (aborted) begin
            int late = 0;
            for (int k = 0; k < 6; k++) begin
                @(negedge clk);
                if (bif.dma_done || bif.dma_hijack) late++;
            end
            checkOutput({name, "_post_rst_quiet"}, late, 0);
            checkOutput({name, "_wr_before_rst"}, nWr, resetAtWe);
            checkOutput({name, "_wr_data"}, wrErr, 0);
            return;
        end
        checkOutput({name, "_finished"}, finished, 1);
        checkOutput({name, "_hijack_cycles"}, hij, expHijack);
        checkOutput({name, "_write_count"}, nWr, 256);
        checkOutput({name, "_read_count"}, nRd, 256);
        checkOutput({name, "_write_data"}, wrErr, 0);
        checkOutput({name, "_read_addr"}, rdErr, 0);
        checkOutput({name, "_read_parity"}, parErr, 0);
        checkOutput({name, "_done_pulses"}, dones, 1);
    endtask

    task automatic waitPar(input bit want);
        for (int k = 0; k < 4 && tbPar != want; k++) @(negedge clk);
    endtask

    initial begin
        bif.bus_addr      = 16'h0000;
        bif.bus_wr        = 1'b1;
        bif.oam_addr_base = 8'h00;
        cpuDin            = 8'h00;
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'hA5;

        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", outVec(), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_outputs", outVec(), 64'd0);

        $display("[TB] page 02, base 00, even trigger");
        waitPar(1'b0);
        applyStimulus(8'h02, 8'h00);
        monitorTransfer("even", -1, 0);
        @(negedge clk);
        checkOutput("even_done_once", bif.dma_done, 0);

        $display("[TB] page 02, odd trigger, stray $4014 write mid-transfer");
        waitPar(1'b1);
        applyStimulus(8'h02, 8'h00);
        monitorTransfer("odd", 60, 0);
        @(negedge clk);

        $display("[TB] page 07, base F0 wrap");
        applyStimulus(8'h07, 8'hF0);
        checkOutput("wrap_first_write", expWrites[0], {8'hF0, mem[16'h0700]});
        checkOutput("wrap_zero_write", expWrites[16], {8'h00, mem[16'h0710]});
        monitorTransfer("wrap", -1, 0);
        @(negedge clk);

        $display("[TB] reset after 100th OAM write");
        applyStimulus(8'h03, 8'($urandom));
        monitorTransfer("abort", -1, 100);
        applyStimulus(8'h04, 8'($urandom));
        monitorTransfer("recover", -1, 0);
        @(negedge clk);

        $display("[TB] non-trigger bus cycles");
        bif.bus_addr = 16'h4015; bif.bus_wr = 1'b0; cpuDin = 8'h02;
        @(negedge clk);
        checkOutput("wr_4015", outVec(), 64'd0);
        bif.bus_addr = 16'h2014;
        @(negedge clk);
        checkOutput("wr_2014", outVec(), 64'd0);
        bif.bus_addr = 16'h4014; bif.bus_wr = 1'b1;
        @(negedge clk);
        checkOutput("rd_4014", outVec(), 64'd0);
        bif.bus_addr = 16'h0000;
        @(negedge clk);
        checkOutput("after_rd_4014", outVec(), 64'd0);

        $display("[TB] page FF then back-to-back trigger on dma_done");
        applyStimulus(8'hFF, 8'($urandom));
        monitorTransfer("pageff", -1, 0);
        applyStimulus(8'h05, 8'($urandom));
        checkOutput("b2b_halt_hijack", bif.dma_hijack, 1);
        monitorTransfer("b2b", -1, 0);
        @(negedge clk);
        checkOutput("b2b_done_once", bif.dma_done, 0);
        checkOutput("final_idle", outVec(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oam_dma_ctrl.md
Name: oam_dma_ctrl

Overview:
- Sprite (OAM) DMA sequencer for the $4014 register.
- Detects a CPU write to $4014, then raises dma_hijack to stall the CPU and take over the system bus.
- Copies 256 bytes from CPU page $XX00-$XXFF into PPU OAM as alternating read/write cycles, with NES-accurate odd-cycle alignment.
- Sits between the CPU bus and the PPU OAM write port. dma_hijack drives the CPU enable (CPU runs when low) and the databus address mux.

Parameters:
- DMA_REG_ADDR, 16'h4014, CPU address that triggers DMA.
- XFER_LEN, 256, bytes per transfer; must be a power of 2 and ≤256.

Ports:
- cpu_clk  in  1  CPU-rate clock; the single clock of the block.
- reset  in  1  synchronous, active-high reset.
- bus_addr  in  16  CPU bus address.
- bus_wr  in  1  CPU R/W_n: 0 = CPU write cycle.
- bus_din  in  8  shared data bus: CPU write data during CPU writes, memory read data during DMA reads.
- oam_addr_base  in  8  current PPU OAMADDR ($2003 value).
- dma_hijack  out  1  DMA owns the bus; CPU stalled.
- dma_addr  out  16  DMA read address, {page, idx}.
- oam_we  out  1  OAM write strobe.
- oam_addr  out  8  OAM write address.
- oam_data  out  8  OAM write data.
- dma_done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset values: all outputs 0; state IDLE; idx 0; par 0.
- par: free-running parity flop. Resets to 0, toggles every cycle.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- Trigger: in IDLE, a cycle with bus_wr==0 and bus_addr==DMA_REG_ADDR latches on that edge:
  - page ← bus_din
  - base ← oam_addr_base
  - idx ← 0
  - next state HALT
- dma_hijack is registered, =1 in every non-IDLE state.
- HALT: always exactly 1 cycle. Next state is READ if par==1 during HALT, else ALIGN.
- ALIGN: 1 cycle, then READ. Net rule: every READ cycle has par==0.
- READ:
  - dma_addr = {page, idx}.
  - bus_din is sampled at the end of the cycle into data_r.
  - Next state WRITE.
- WRITE:
  - oam_we=1, oam_addr = base+idx (mod 256), oam_data = data_r, dma_addr=0.
  - If idx==XFER_LEN-1: next state IDLE and dma_done=1 in the first IDLE cycle.
  - Else: idx+1, next state READ.
- Hijack duration: 1 + 2·XFER_LEN cycles when the trigger is sampled with par==0 (513 for 256); 2 + 2·XFER_LEN otherwise (514).
- Outside READ, dma_addr=0; outside WRITE, oam_we=0 and oam_addr/oam_data=0.
- Address wrap:
  - oam_addr wraps mod 256, e.g. base $F0 → $F0..$FF, $00..$EF.
  - dma_addr never crosses the page; page $FF reads $FF00-$FFFF.
- Writes to DMA_REG_ADDR while not IDLE are ignored; the CPU is stalled, so this is only reachable in simulation.
- A write to $4014 on the same edge dma_done fires is accepted; the block returns to HALT the next cycle.
- Reset mid-transfer: on the next edge, state IDLE, hijack 0, oam_we 0, no dma_done pulse. Partial OAM contents remain.
- oam_addr_base changes after the trigger have no effect.

Decomposition:
- Shared package nes_pkg:
  - dma_state_t enum {IDLE, HALT, ALIGN, READ, WRITE}
  - localparam NES_OAMDMA_ADDR = 16'h4014
- Single flat module; no sub-module needed. The parity flop and idx counter are inline.

Test Plan:
- Write $02 to $4014 with par==0 at the trigger edge, base=$00, memory[$0200+i]=i^$A5 → hijack high exactly 513 cycles; 256 oam_we pulses with oam_addr=i, oam_data=i^$A5; dma_addr=$0200..$02FF on READ cycles only; one dma_done pulse.
- Same trigger with par==1 → exactly 514 hijack cycles (ALIGN present); first READ on a par==0 cycle.
- base=$F0, page $07 → first write at oam_addr $F0 with data mem[$0700]; oam_addr $00 carries mem[$0710]; last write at $EF.
- Assert reset for 1 cycle after the 100th oam_we → next cycle hijack=0, oam_we=0, dma_done stays 0; a fresh $4014 write afterwards completes normally.
- Writes to $4015 and $2014, and a read of $4014 (bus_wr=1) → no hijack, all outputs remain 0.
- Page $FF, then a second trigger on the dma_done cycle → first transfer reads $FF00-$FFFF; second transfer starts HALT the next cycle, back-to-back with no gap.
